// File: rtl/game_pkg.sv
// Shared game-side definitions for the shot engine and related blocks.
// Contents: coordinate width, playfield limits, spawn offset and the
// shot engine state type.
package game_pkg;

  localparam int COORD_W        = 10;
  localparam int PLAY_Y_MIN     = 8;
  localparam int PLAY_X_MIN     = 8;
  localparam int PLAY_X_MAX     = 432;
  localparam int SPAWN_Y_OFFSET = 16;

  typedef enum logic [1:0] {
    IDLE,
    FIGHT,
    DEAD
  } shot_state_t;

endpackage

// File: rtl/shot_hitbox.sv
// Combinational box test: is point (x, y) strictly inside the box centred
// on (cx, cy) with half sizes half_w / half_h?
// Ports:
//   x, y     point under test
//   cx, cy   box centre
//   half_w   half-width  (strict less-than)
//   half_h   half-height (strict less-than)
//   hit      1 when both distances are inside
module shot_hitbox
  import game_pkg::*;
(
  input  logic [COORD_W-1:0] x,
  input  logic [COORD_W-1:0] y,
  input  logic [COORD_W-1:0] cx,
  input  logic [COORD_W-1:0] cy,
  input  logic [COORD_W-1:0] half_w,
  input  logic [COORD_W-1:0] half_h,
  output logic               hit
);

  logic [COORD_W-1:0] dx;
  logic [COORD_W-1:0] dy;

  // Larger minus smaller, so the distance never wraps.
  always_comb begin
    dx  = (x >= cx) ? (x - cx) : (cx - x);
    dy  = (y >= cy) ? (y - cy) : (cy - y);
    hit = (dx < half_w) && (dy < half_h);
  end

endmodule

// File: rtl/reimu_shot_ctrl.sv
// Player shot engine: spawns upward bullets from the fire button, moves
// them one step per clk22 tick, hit-tests them against the boss box and
// tracks boss HP with a defeat flag.
// Optional feature macro: REIMU_SHOT_FOCUS_EN (adds input focus; while
// focus=1 each hit deals 2 damage).
// Ports:
//   clk22, rst        game tick clock, synchronous active-high reset
//   gamestart         title screen active, holds the block cleared
//   boss              boss phase active
//   fire              shoot button (level)
//   reimux, reimuy    player centre
//   bossx, bossy      boss centre
//   bullet_valid      per-slot exists flag
//   bullet_x/_y       slot i at [10*i+9:10*i]
//   boss_hit          one-tick pulse, at least one hit last tick
//   boss_hp           remaining HP
//   boss_dead         HP reached zero (level, DEAD state)
module reimu_shot_ctrl
  import game_pkg::*;
#(
  parameter int NUM_BULLETS = 4,
  parameter int COOLDOWN    = 3,
  parameter int SPEED       = 12,
  parameter int BOSS_HP     = 64,
  parameter int HIT_DX      = 24,
  parameter int HIT_DY      = 24
) (
  input  logic                           clk22,
  input  logic                           rst,
  input  logic                           gamestart,
  input  logic                           boss,
  input  logic                           fire,
`ifdef REIMU_SHOT_FOCUS_EN
  input  logic                           focus,
`endif
  input  logic [COORD_W-1:0]             reimux,
  input  logic [COORD_W-1:0]             reimuy,
  input  logic [COORD_W-1:0]             bossx,
  input  logic [COORD_W-1:0]             bossy,
  output logic [NUM_BULLETS-1:0]         bullet_valid,
  output logic [COORD_W*NUM_BULLETS-1:0] bullet_x,
  output logic [COORD_W*NUM_BULLETS-1:0] bullet_y,
  output logic                           boss_hit,
  output logic [7:0]                     boss_hp,
  output logic                           boss_dead
);

  localparam logic [COORD_W-1:0] STEP        = COORD_W'(SPEED);
  // A bullet above this line would leave the playfield on its next step.
  localparam logic [COORD_W-1:0] TOP_LIM     = COORD_W'(SPEED + PLAY_Y_MIN);
  // Lowest player y whose spawn point stays inside the playfield.
  localparam logic [COORD_W-1:0] SPAWN_MIN_Y = COORD_W'(SPAWN_Y_OFFSET + PLAY_Y_MIN);
  localparam logic [7:0]         HP_INIT     = 8'(BOSS_HP);
  localparam logic [7:0]         CD_INIT     = 8'(COOLDOWN);

  function automatic logic [7:0] sat_sub(input logic [7:0] a, input logic [7:0] b);
    return (b >= a) ? 8'd0 : (a - b);
  endfunction

  shot_state_t              state;
  logic [NUM_BULLETS-1:0]   sv;
  logic [COORD_W-1:0]       sx [NUM_BULLETS];
  logic [COORD_W-1:0]       sy [NUM_BULLETS];
  logic [7:0]               cooldown;

  logic [NUM_BULLETS-1:0]   raw_hit;
  logic [NUM_BULLETS-1:0]   hit_vec;
  logic [NUM_BULLETS-1:0]   free_vec;
  logic [7:0]               hit_cnt;
  logic [7:0]               dmg;
  logic [7:0]               hp_next;
  logic                     spawn_ok;
  int                       spawn_idx;

  for (genvar g = 0; g < NUM_BULLETS; g++) begin : g_slot
    shot_hitbox u_hitbox (
      .x      (sx[g]),
      .y      (sy[g]),
      .cx     (bossx),
      .cy     (bossy),
      .half_w (COORD_W'(HIT_DX)),
      .half_h (COORD_W'(HIT_DY)),
      .hit    (raw_hit[g])
    );
    assign bullet_x[COORD_W*g +: COORD_W] = sx[g];
    assign bullet_y[COORD_W*g +: COORD_W] = sy[g];
  end

  assign bullet_valid = sv;

  // Per-slot outcome on registered positions: hit beats top exit.
  always_comb begin
    hit_cnt   = 8'd0;
    spawn_idx = 0;
    spawn_ok  = 1'b0;
    for (int i = 0; i < NUM_BULLETS; i++) begin
      hit_vec[i]  = sv[i] & raw_hit[i];
      free_vec[i] = ~sv[i] | raw_hit[i] | (sy[i] < TOP_LIM);
      hit_cnt     = hit_cnt + {7'd0, hit_vec[i]};
    end
`ifdef REIMU_SHOT_FOCUS_EN
    dmg = focus ? {hit_cnt[6:0], 1'b0} : hit_cnt;
`else
    dmg = hit_cnt;
`endif
    hp_next = sat_sub(boss_hp, dmg);
    // Downward scan leaves the lowest free index selected.
    for (int i = NUM_BULLETS - 1; i >= 0; i--) begin
      if (free_vec[i]) begin
        spawn_idx = i;
        spawn_ok  = 1'b1;
      end
    end
    spawn_ok = spawn_ok & fire & (cooldown == 8'd0) & (reimuy >= SPAWN_MIN_Y);
  end

  always_ff @(posedge clk22) begin
    if (rst || gamestart) begin
      state     <= IDLE;
      sv        <= '0;
      cooldown  <= 8'd0;
      boss_hit  <= 1'b0;
      boss_hp   <= HP_INIT;
      boss_dead <= 1'b0;
      for (int i = 0; i < NUM_BULLETS; i++) begin
        sx[i] <= '0;
        sy[i] <= '0;
      end
    end else begin
      boss_hit <= 1'b0;
      if (cooldown != 8'd0) cooldown <= cooldown - 8'd1;
      case (state)
        IDLE: begin
          sv <= '0;
          for (int i = 0; i < NUM_BULLETS; i++) begin
            sx[i] <= '0;
            sy[i] <= '0;
          end
          if (boss) begin
            state   <= FIGHT;
            boss_hp <= HP_INIT;
          end
        end
        FIGHT: begin
          if (!boss) begin
            state <= IDLE;
            sv    <= '0;
            for (int i = 0; i < NUM_BULLETS; i++) begin
              sx[i] <= '0;
              sy[i] <= '0;
            end
          end else begin
            boss_hp  <= hp_next;
            boss_hit <= |hit_vec;
            if (hp_next == 8'd0) begin
              state     <= DEAD;
              boss_dead <= 1'b1;
              sv        <= '0;
              for (int i = 0; i < NUM_BULLETS; i++) begin
                sx[i] <= '0;
                sy[i] <= '0;
              end
            end else begin
              for (int i = 0; i < NUM_BULLETS; i++) begin
                if (free_vec[i]) sv[i] <= 1'b0;
                else             sy[i] <= sy[i] - STEP;
              end
              // Later assignment wins over the free above for the chosen slot.
              if (spawn_ok) begin
                cooldown <= CD_INIT;
                for (int i = 0; i < NUM_BULLETS; i++) begin
                  if (i == spawn_idx) begin
                    sv[i] <= 1'b1;
                    sx[i] <= reimux;
                    sy[i] <= reimuy - COORD_W'(SPAWN_Y_OFFSET);
                  end
                end
              end
            end
          end
        end
        DEAD: begin
          sv <= '0;
          for (int i = 0; i < NUM_BULLETS; i++) begin
            sx[i] <= '0;
            sy[i] <= '0;
          end
          if (!boss) begin
            state     <= IDLE;
            boss_dead <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_reimu_shot_ctrl.sv
// Bench for reimu_shot_ctrl: directed scenarios with literal expectations
// followed by randomized stimulus, all checked every cycle against a
// behavioural model of the shot engine.
module tb_reimu_shot_ctrl;

  localparam int N = 4;

  logic            clk22 = 1'b0;
  logic            rst, gamestart, boss, fire;
`ifdef REIMU_SHOT_FOCUS_EN
  logic            focus;
`endif
  logic [9:0]      reimux, reimuy, bossx, bossy;
  logic [N-1:0]    bullet_valid;
  logic [10*N-1:0] bullet_x, bullet_y;
  logic            boss_hit;
  logic [7:0]      boss_hp;
  logic            boss_dead;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  always #5 clk22 = ~clk22;

  reimu_shot_ctrl dut (
    .clk22        (clk22),
    .rst          (rst),
    .gamestart    (gamestart),
    .boss         (boss),
    .fire         (fire),
`ifdef REIMU_SHOT_FOCUS_EN
    .focus        (focus),
`endif
    .reimux       (reimux),
    .reimuy       (reimuy),
    .bossx        (bossx),
    .bossy        (bossy),
    .bullet_valid (bullet_valid),
    .bullet_x     (bullet_x),
    .bullet_y     (bullet_y),
    .boss_hit     (boss_hit),
    .boss_hp      (boss_hp),
    .boss_dead    (boss_dead)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // m_mode: 0 waiting for boss, 1 fighting, 2 boss defeated
  int m_mode;
  bit m_v [N];
  int m_x [N];
  int m_y [N];
  int m_cd, m_hp;
  bit m_hit, m_dead;

  function automatic int absd(input int a, input int b);
    return (a > b) ? a - b : b - a;
  endfunction

  task automatic m_clear();
    for (int i = 0; i < N; i++) begin
      m_v[i] = 1'b0; m_x[i] = 0; m_y[i] = 0;
    end
  endtask

  task automatic m_step();
    int hits, dmg, cd_next, slot;
    if (rst || gamestart) begin
      m_mode = 0; m_clear(); m_cd = 0; m_hit = 0; m_hp = 64; m_dead = 0;
    end else begin
      cd_next = (m_cd > 0) ? m_cd - 1 : 0;
      m_hit   = 0;
      if (m_mode == 0) begin
        m_clear();
        if (boss) begin m_mode = 1; m_hp = 64; end
      end else if (m_mode == 2) begin
        m_clear();
        if (!boss) begin m_mode = 0; m_dead = 0; end
      end else if (!boss) begin
        m_mode = 0; m_clear();
      end else begin
        hits = 0;
        for (int i = 0; i < N; i++) begin
          if (m_v[i]) begin
            if (absd(m_x[i], int'(bossx)) < 24 && absd(m_y[i], int'(bossy)) < 24) begin
              m_v[i] = 0; hits++;
            end else if (m_y[i] < 20) m_v[i] = 0;
            else m_y[i] = m_y[i] - 12;
          end
        end
        dmg = hits;
`ifdef REIMU_SHOT_FOCUS_EN
        if (focus) dmg = 2 * hits;
`endif
        m_hp  = (m_hp > dmg) ? m_hp - dmg : 0;
        m_hit = (hits > 0);
        if (m_hp == 0) begin
          m_mode = 2; m_dead = 1; m_clear();
        end else if (fire && m_cd == 0 && reimuy >= 24) begin
          slot = -1;
          for (int i = N - 1; i >= 0; i--) if (!m_v[i]) slot = i;
          if (slot >= 0) begin
            m_v[slot] = 1; m_x[slot] = int'(reimux); m_y[slot] = int'(reimuy) - 16;
            cd_next = 3;
          end
        end
      end
      m_cd = cd_next;
    end
  endtask

  always @(posedge clk22) m_step();

  // Compare process: outputs are stable at the falling edge.
  always @(negedge clk22) begin
    if (chk_en) begin
      for (int i = 0; i < N; i++) begin
        check($sformatf("valid%0d", i), bullet_valid[i], m_v[i]);
        if (m_v[i]) begin
          check($sformatf("x%0d", i), bullet_x[10*i +: 10], m_x[i]);
          check($sformatf("y%0d", i), bullet_y[10*i +: 10], m_y[i]);
        end
      end
      check("boss_hit", boss_hit, m_hit);
      check("boss_hp", boss_hp, m_hp);
      check("boss_dead", boss_dead, m_dead);
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk22);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt, guard;
    rst = 1; gamestart = 0; boss = 0; fire = 0;
    reimux = 0; reimuy = 0; bossx = 0; bossy = 0;
`ifdef REIMU_SHOT_FOCUS_EN
    focus = 0;
`endif
    step(2);
    chk_en = 1;
    check("rst_valid", bullet_valid, 0);
    check("rst_hp", boss_hp, 64);
    check("rst_dead", boss_dead, 0);
    check("rst_hit", boss_hit, 0);
    rst = 0;

    // Single-shot flight, boss far away
    boss = 1; bossx = 50; bossy = 100; reimux = 300; reimuy = 400;
    step(1);
    fire = 1; step(1); fire = 0;
    check("s1_y0", bullet_y[9:0], 384);
    check("s1_x0", bullet_x[9:0], 300);
    cnt = 0;
    for (int k = 0; k < 60; k++) begin
      if (bullet_valid[0]) cnt++;
      if (k == 1) check("s1_y1", bullet_y[9:0], 372);
      step(1);
    end
    check("s1_life", cnt, 32);
    check("s1_hp", boss_hp, 64);

    // Single-shot hit
    bossx = 200; reimux = 200;
    fire = 1; step(1); fire = 0;
    check("s2_y0", bullet_y[9:0], 384);
    step(22);
    check("s2_y22", bullet_y[9:0], 120);
    step(1);
    check("s2_freed", bullet_valid[0], 0);
    check("s2_hit", boss_hit, 1);
    check("s2_hp", boss_hp, 63);
    step(1);
    check("s2_hit_pulse", boss_hit, 0);

    // Mid-flight reset via gamestart
    bossx = 50; reimux = 300; fire = 1;
    step(6);
    check("s5_inflight", bullet_valid != 0, 1);
    gamestart = 1; fire = 0; step(1); gamestart = 0;
    check("s5_valid", bullet_valid, 0);
    check("s5_hp", boss_hp, 64);
    check("s5_xy", |{bullet_x, bullet_y}, 0);
    step(1);

    // Held fire with cooldown, pool exhaustion
    fire = 1;
    for (int k = 0; k <= 32; k++) begin
      step(1);
      if (k == 0)  check("s3_e0", bullet_valid, 4'b0001);
      if (k == 3)  check("s3_e3", bullet_valid, 4'b0001);
      if (k == 4)  check("s3_e4", bullet_valid, 4'b0011);
      if (k == 8)  check("s3_e8", bullet_valid, 4'b0111);
      if (k == 12) check("s3_e12", bullet_valid, 4'b1111);
      if (k == 31) check("s3_y31", bullet_y[9:0], 12);
      if (k == 32) begin
        check("s3_e32", bullet_valid, 4'b1111);
        check("s3_y32", bullet_y[9:0], 384);
      end
    end
    fire = 0; boss = 0; step(1);
    check("s6_exit_valid", bullet_valid, 0);
    boss = 1; step(1);
    check("s6_reload", boss_hp, 64);

    // Drain HP to exactly 1
    bossx = 200; bossy = 100; reimux = 200; reimuy = 140; fire = 1;
    guard = 0;
    while (guard < 600 && !(fire == 0 && bullet_valid == 0)) begin
      if (int'(boss_hp) - $countones(bullet_valid) <= 1) fire = 0;
      step(1); guard++;
    end
    check("s4_hp1", boss_hp, 1);

    // Two bullets at the same height, both hit with hp=1
    bossx = 50; reimux = 300; reimuy = 400; fire = 0; step(4);
    fire = 1; step(1); fire = 0; step(3);
    fire = 1; reimuy = 352; step(1);
    check("s4_y0", bullet_y[9:0], 336);
    check("s4_y1", bullet_y[19:10], 336);
    bossx = 300; bossy = 330; step(1);
    check("s4_hp0", boss_hp, 0);
    check("s4_dead", boss_dead, 1);
    check("s4_valid", bullet_valid, 0);
    check("s4_hit", boss_hit, 1);
    step(3);
    check("s4_fire_ignored", bullet_valid, 0);
    boss = 0; fire = 0; step(1);
    check("s4_undead", boss_dead, 0);
    boss = 1; step(1);
    check("s4_reload", boss_hp, 64);

    // Randomized phase
    for (int k = 0; k < 3000; k++) begin
      rst       = ($urandom_range(0, 499) == 0);
      gamestart = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 99) == 0) boss = ~boss;
      fire   = ($urandom_range(0, 3) != 0);
      reimux = 10'($urandom_range(150, 350));
      reimuy = 10'($urandom_range(0, 479));
      bossx  = 10'($urandom_range(150, 350));
      bossy  = 10'($urandom_range(40, 300));
`ifdef REIMU_SHOT_FOCUS_EN
      focus  = $urandom_range(0, 1) != 0;
`endif
      step(1);
    end

    chk_en = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
